hex_word_formatter: RTL and testbench
=====================================

Name: hex_word_formatter

Overview:
- Upstream feeder for the UART TX path.
- Accepts a debug data word over a valid/ready handshake and converts it to ASCII hex characters, most-significant nibble first, optionally followed by CR LF.
- Pushes characters one per cycle into the UART TX FIFO through its wr_uart/w_data/tx_full interface, stalling while the FIFO is full.
- Lets Ethernet debug logic print raw words on a serial terminal.

Parameters:
- NIBBLES, 8: hex digits per word; input width is 4*NIBBLES; legal range 1..16.
- UPPER, 1: 1 = digits A-F emitted as 0x41-0x46; 0 = a-f emitted as 0x61-0x66.
- NEWLINE, 1: 1 = append CR (0x0D) then LF (0x0A) after the digits; 0 = digits only.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- din  input  4*NIBBLES  word to print; sampled only on the accept edge.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word (registered).
- wr_uart  output  1  write strobe to the UART TX FIFO.
- w_data  output  8  ASCII character to the FIFO.
- tx_full  input  1  FIFO full flag from the UART.
- busy  output  1  high from accept until the last character is written.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, din_ready=0, busy=0, wr_uart=0.
  - Shift register and counter cleared; w_data=0x00.
- din_ready is a register loaded with (next_state==IDLE).
  - It goes to 1 on the first rising edge after reset is released.
- States: IDLE, HEX, CR, LF.
- IDLE:
  - On an edge with din_valid & din_ready: latch din into the shift register, load the nibble counter with NIBBLES-1, go to HEX.
  - din_ready=0 and busy=1 from the next cycle.
- HEX:
  - w_data = ASCII of the top nibble of the shift register.
    - 0-9 maps to 0x30+n.
    - 10-15 maps to 0x41+(n-10) when UPPER=1, else 0x61+(n-10).
  - wr_uart = ~tx_full (combinational, in all emit states).
  - On an edge with wr_uart=1: shift the register left 4 bits and decrement the counter.
  - When the counter is 0 at that edge: go to CR if NEWLINE=1, else IDLE.
  - With wr_uart=0 (tx_full=1): hold all state; w_data stays stable.
- CR: w_data=0x0D; on a write edge go to LF.
- LF: w_data=0x0A; on a write edge go to IDLE.
- Outside HEX/CR/LF: wr_uart=0 and w_data=0x00.
- Throughput:
  - First write is possible in the cycle after accept.
  - With tx_full=0 throughout, a word produces NIBBLES+2 writes on consecutive cycles (NIBBLES if NEWLINE=0).
  - The next accept is possible on the edge after the final write; back-to-back words are spaced NIBBLES+3 cycles apart.
- Boundary rules:
  - Never assert wr_uart while tx_full=1. The FIFO would drop the byte and the character would be lost.
  - tx_full rising mid-word stalls at the current character; nothing is skipped or duplicated.
  - din and din_valid are ignored while not in IDLE; a producer holding valid waits for ready.
  - Reset asserted mid-word aborts immediately. No partial CR/LF is emitted after release, and the aborted word is not resumed.

Test Plan:
- Reset release, then din=0x1234ABCD with din_valid=1, tx_full=0 -> writes "1234ABCD\r\n" (0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A) on 10 consecutive cycles starting one cycle after accept; din_ready back to 1 the cycle after the LF write.
- Same word, tx_full forced 1 for 3 cycles while the '3' character is pending -> wr_uart=0 for those 3 cycles with w_data=0x33 held; total 10 writes in correct order, no duplicates.
- Two words 0x00000000 and 0xFFFFFFFF presented back-to-back with din_valid held high -> "00000000\r\n" then "FFFFFFFF\r\n"; accepts 11 cycles apart.
- UPPER=0, NEWLINE=0, NIBBLES=4, din=0xBEEF -> exactly 4 writes: 0x62 0x65 0x65 0x66; no CR/LF.
- Reset pulsed low after the 3rd character of 0xDEADBEEF -> wr_uart drops to 0 asynchronously and din_ready=0 during reset; after release, din_ready=1 after one edge; the next word prints fully with no leftover characters.
- din changed while busy with din_valid=1 -> output still reflects the word latched at accept; the new word is accepted only when din_ready=1.

Source files
------------

// File: rtl/hex_word_formatter.sv
// hex_word_formatter: accepts a data word over valid/ready and streams it to
// the UART TX FIFO as ASCII hex, most-significant nibble first, optionally
// followed by CR LF. Writes stall while the FIFO reports full.
module hex_word_formatter #(
    parameter int NIBBLES = 8,     // hex digits per word, 1..16
    parameter bit UPPER   = 1'b1,  // 1: 'A'-'F', 0: 'a'-'f'
    parameter bit NEWLINE = 1'b1   // 1: append CR LF after the digits
) (
    input  logic                   clk,
    input  logic                   reset,      // asynchronous, active-low
    input  logic [4*NIBBLES-1:0]   din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic                   wr_uart,
    output logic [7:0]             w_data,
    input  logic                   tx_full,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, HEX, CR, LF} state_t;

    state_t          state;
    state_t          next_state;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic            accept;

    // A word is taken only in IDLE, so din/din_valid are ignored while busy.
    assign accept = (state == IDLE) && din_valid && din_ready;
    assign busy   = (state != IDLE);

    // Map one nibble to its ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else if (UPPER)
            return 8'h37 + {4'h0, n};   // 0x41 - 10
        else
            return 8'h57 + {4'h0, n};   // 0x61 - 10
    endfunction

    // Next-state and FIFO-side outputs; a write only happens when the FIFO has room.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        wr_uart    = 1'b0;
        w_data     = 8'h00;
        unique case (state)
            IDLE: begin
                if (accept)
                    next_state = HEX;
            end
            HEX: begin
                wr_uart = ~tx_full;
                w_data  = hex_ascii(shreg[W-1 -: 4]);
                if (!tx_full && cnt == '0)
                    next_state = NEWLINE ? CR : IDLE;
            end
            CR: begin
                wr_uart = ~tx_full;
                w_data  = 8'h0D;
                if (!tx_full)
                    next_state = LF;
            end
            LF: begin
                wr_uart = ~tx_full;
                w_data  = 8'h0A;
                if (!tx_full)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; din_ready is registered from the next state so it is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state     <= IDLE;
            din_ready <= 1'b0;
        end else begin
            state     <= next_state;
            din_ready <= (next_state == IDLE);
        end
    end

    // Datapath: latch the word on accept, advance one nibble per digit written.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the datapath is cleared on reset so an aborted word cannot leak into the next one.
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= din;
            cnt   <= CW'(NIBBLES - 1);
        end else if (state == HEX && wr_uart) begin
            shreg <= shreg << 4;
            cnt   <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hex_word_formatter.sv
// Directed bench for hex_word_formatter: default 8-digit upper-case CR/LF
// instance plus a 4-digit lower-case instance with no line ending.
module tb_hex_word_formatter;

    logic        clk;
    logic        reset;

    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        tx_full;
    logic        busy;

    logic [15:0] din4;
    logic        din_valid4;
    logic        din_ready4;
    logic        wr_uart4;
    logic [7:0]  w_data4;
    logic        tx_full4;
    logic        busy4;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cyc           = 0;
    int t_acc_a;
    int t_acc_b;

    hex_word_formatter #(.NIBBLES(8), .UPPER(1'b1), .NEWLINE(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .tx_full   (tx_full),
        .busy      (busy)
    );

    hex_word_formatter #(.NIBBLES(4), .UPPER(1'b0), .NEWLINE(1'b0)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .din       (din4),
        .din_valid (din_valid4),
        .din_ready (din_ready4),
        .wr_uart   (wr_uart4),
        .w_data    (w_data4),
        .tx_full   (tx_full4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected)
        else begin
            n_miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word on the 8-digit instance and let it be accepted; records the accept cycle.
    task automatic accept8(input logic [31:0] w, output int t_acc);
        din       = w;
        din_valid = 1'b1;
        #1;
        check("ready_before_accept", din_ready, 1'b1);
        t_acc = cyc;
        tick();
        check("busy_after_accept", busy, 1'b1);
        check("ready_low_after_accept", din_ready, 1'b0);
    endtask

    // Expect the 10 characters in exp (first char in the top byte), optionally
    // holding tx_full high for stall_n cycles while character stall_at is pending.
    task automatic emit8(input logic [79:0] exp, input int stall_at, input int stall_n);
        logic [7:0] ch;
        for (int i = 0; i < 10; i++) begin
            ch = exp[79 - 8*i -: 8];
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    tx_full = 1'b1;
                    #1;
                    check("stall_wr_low", wr_uart, 1'b0);
                    check("stall_data_held", w_data, ch);
                    tick();
                end
            end
            tx_full = 1'b0;
            #1;
            check("char_wr", wr_uart, 1'b1);
            check("char_data", w_data, ch);
            check("ready_low_busy", din_ready, 1'b0);
            tick();
        end
        #1;
        check("post_word_wr", wr_uart, 1'b0);
        check("post_word_busy", busy, 1'b0);
        check("post_word_ready", din_ready, 1'b1);
        check("post_word_data", w_data, 8'h00);
    endtask

    initial begin
        logic [79:0] exp_str;
        logic [31:0] exp4;

        reset      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        tx_full    = 1'b0;
        din4       = '0;
        din_valid4 = 1'b0;
        tx_full4   = 1'b0;

        // Reset state
        #3;
        check("rst_ready", din_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr", wr_uart, 1'b0);
        check("rst_data", w_data, 8'h00);
        check("rst_ready4", din_ready4, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("ready_before_first_edge", din_ready, 1'b0);
        tick();
        check("ready_after_release", din_ready, 1'b1);

        // Plain word with CR LF
        accept8(32'h1234ABCD, t_acc_a);
        din_valid = 1'b0;
        exp_str = {8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        emit8(exp_str, -1, 0);

        // Same word, FIFO full for 3 cycles while '3' is pending
        accept8(32'h1234ABCD, t_acc_a);
        din_valid = 1'b0;
        emit8(exp_str, 2, 3);

        // Back-to-back words with din_valid held; din changes while busy
        accept8(32'h00000000, t_acc_a);
        din = 32'hFFFFFFFF;
        exp_str = {{8{8'h30}}, 8'h0D, 8'h0A};
        emit8(exp_str, -1, 0);
        accept8(32'hFFFFFFFF, t_acc_b);
        din_valid = 1'b0;
        check("accept_spacing", t_acc_b - t_acc_a, 32'd11);
        exp_str = {{8{8'h46}}, 8'h0D, 8'h0A};
        emit8(exp_str, -1, 0);

        // Reset pulsed mid-word after the 3rd character of 0xDEADBEEF
        accept8(32'hDEADBEEF, t_acc_a);
        din_valid = 1'b0;
        check("dead_c0", w_data, 8'h44);
        tick();
        check("dead_c1", w_data, 8'h45);
        tick();
        check("dead_c2", w_data, 8'h41);
        tick();
        check("dead_c3_pending", wr_uart, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_wr", wr_uart, 1'b0);
        check("abort_ready", din_ready, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_data", w_data, 8'h00);
        tick();
        reset = 1'b1;
        #1;
        check("abort_release_ready", din_ready, 1'b0);
        check("abort_release_wr", wr_uart, 1'b0);
        tick();
        check("abort_ready_after_edge", din_ready, 1'b1);
        check("abort_no_leftover", wr_uart, 1'b0);
        accept8(32'h9876FEDC, t_acc_a);
        din_valid = 1'b0;
        exp_str = {8'h39, 8'h38, 8'h37, 8'h36, 8'h46, 8'h45, 8'h44, 8'h43, 8'h0D, 8'h0A};
        emit8(exp_str, -1, 0);

        // 4-digit lower-case instance, no CR LF
        din4       = 16'hBEEF;
        din_valid4 = 1'b1;
        #1;
        check("i4_ready_before", din_ready4, 1'b1);
        tick();
        din_valid4 = 1'b0;
        exp4 = {8'h62, 8'h65, 8'h65, 8'h66};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("i4_wr", wr_uart4, 1'b1);
            check("i4_data", w_data4, exp4[31 - 8*i -: 8]);
            tick();
        end
        #1;
        check("i4_no_crlf", wr_uart4, 1'b0);
        check("i4_ready_after", din_ready4, 1'b1);
        check("i4_busy_after", busy4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
